contactor_driver: RTL and testbench

- Per-contactor coil sequencer for the ring interlock circuit; one instance per contactor A..H.
- Consumes the operator close command and the permit from that contactor's interlock block, then drives the coil.
- Debounces the auxiliary-contact feedback and returns it as the clean feedback bit that the interlock blocks consume.
- Supervises close/open confirmation with timeouts and latches faults.

---
 rtl/contactor_driver.sv | 151 +++++++++++++++
 tb/tb_contactor_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/contactor_driver.sv
// rtl/contactor_driver.sv - coil sequencer with debounced aux feedback, confirmation timeouts and fault latch
// Optional build macro CONTACTOR_PERMIT_GATE_EN gates the registered coil drive with i_Permit combinationally.
module contactor_driver #(
    parameter int DEBOUNCE      = 4,
    parameter int CLOSE_TIMEOUT = 20,
    parameter int OPEN_TIMEOUT  = 20,
    parameter int CNT_W         = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Cmd,
    input  logic       i_Permit,
    input  logic       i_Aux,
    input  logic       i_FaultClr,
    output logic       o_Coil,
    output logic       o_Fb,
    output logic       o_Busy,
    output logic       o_Fault,
    output logic [1:0] o_FaultCode
);

    typedef enum logic [2:0] {
        ST_OPEN,
        ST_CLOSING,
        ST_CLOSED,
        ST_OPENING,
        ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CLOSE_LAST = CNT_W'(CLOSE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_CLOSE = 2'b01;
    localparam logic [1:0] CODE_OPEN  = 2'b10;
    localparam logic [1:0] CODE_UNEXP = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic             sync1_q;
    logic             aux_s_q;
    logic             fb_q, fb_d;
    logic             coil_reg;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_OPEN;
            code_q  <= CODE_NONE;
            tmo_q   <= '0;
            deb_q   <= '0;
            sync1_q <= 1'b0;
            aux_s_q <= 1'b0;
            fb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            tmo_q   <= tmo_d;
            deb_q   <= deb_d;
            sync1_q <= i_Aux;
            aux_s_q <= sync1_q;
            fb_q    <= fb_d;
        end
    end

    // A disagreement must persist DEBOUNCE consecutive cycles; any agreement restarts the count.
    always_comb begin
        deb_d = '0;
        fb_d  = fb_q;
        if (aux_s_q != fb_q) begin
            if (deb_q == DEB_LAST) begin
                fb_d = aux_s_q;
            end else begin
                deb_d = deb_q + CNT_ONE;
            end
        end
    end

    // Timeout counter defaults to zero, so any transition into a busy state starts it fresh.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tmo_d   = '0;
        case (state_q)
            ST_OPEN: begin
                if (fb_q) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_UNEXP;
                end else if (i_Cmd && i_Permit) begin
                    state_d = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                if (fb_q) begin
                    state_d = ST_CLOSED;
                end else if (!i_Permit || !i_Cmd) begin
                    state_d = ST_OPENING;
                end else if (tmo_q == CLOSE_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_CLOSE;
                end else begin
                    tmo_d = tmo_q + CNT_ONE;
                end
            end
            ST_CLOSED: begin
                if (!fb_q) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_UNEXP;
                end else if (!i_Permit || !i_Cmd) begin
                    state_d = ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (!fb_q) begin
                    state_d = ST_OPEN;
                end else if (tmo_q == OPEN_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_OPEN;
                end else begin
                    tmo_d = tmo_q + CNT_ONE;
                end
            end
            ST_FAULT: begin
                if (i_FaultClr && !fb_q) begin
                    state_d = ST_OPEN;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = ST_OPEN;
                code_d  = CODE_NONE;
            end
        endcase
    end

    assign coil_reg    = (state_q == ST_CLOSING) || (state_q == ST_CLOSED);
    assign o_Busy      = (state_q == ST_CLOSING) || (state_q == ST_OPENING);
    assign o_Fault     = (state_q == ST_FAULT);
    assign o_FaultCode = code_q;
    assign o_Fb        = fb_q;

`ifdef CONTACTOR_PERMIT_GATE_EN
    assign o_Coil = coil_reg & i_Permit;
`else
    assign o_Coil = coil_reg;
`endif

endmodule

// File: tb/tb_contactor_driver.sv
// tb/tb_contactor_driver.sv - directed and randomized checks of contactor_driver against a behavioural model
module tb_contactor_driver;

    localparam int DEB = 4;
    localparam int CT  = 20;
    localparam int OT  = 20;

    localparam int M_OPEN    = 0;
    localparam int M_CLOSING = 1;
    localparam int M_CLOSED  = 2;
    localparam int M_OPENING = 3;
    localparam int M_FAULT   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd = 1'b0;
    logic       permit = 1'b0;
    logic       aux = 1'b0;
    logic       clr = 1'b0;
    logic       coil, fb, busy, fault;
    logic [1:0] code;

    int n_cmp = 0;
    int n_mis = 0;

    int m_state;
    int m_code;
    int m_time_in_state;
    bit m_fb;
    bit raw_hist[$];

    contactor_driver #(
        .DEBOUNCE(DEB), .CLOSE_TIMEOUT(CT), .OPEN_TIMEOUT(OT), .CNT_W(16)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Cmd(cmd), .i_Permit(permit), .i_Aux(aux),
        .i_FaultClr(clr), .o_Coil(coil), .o_Fb(fb), .o_Busy(busy),
        .o_Fault(fault), .o_FaultCode(code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_OPEN;
        m_code = 0;
        m_time_in_state = 0;
        m_fb = 1'b0;
        raw_hist.delete();
        for (int i = 0; i < DEB + 2; i++) raw_hist.push_back(1'b0);
    endtask

    // Feedback flips once the synchronized aux (raw input two edges back) has disagreed for DEB edges running.
    task automatic model_edge();
        bit flip;
        int ns;
        flip = 1'b1;
        for (int i = 1; i <= DEB; i++) if (raw_hist[i] == m_fb) flip = 1'b0;
        ns = m_state;
        case (m_state)
            M_OPEN: begin
                if (m_fb) begin ns = M_FAULT; m_code = 3; end
                else if (cmd && permit) ns = M_CLOSING;
            end
            M_CLOSING: begin
                if (m_fb) ns = M_CLOSED;
                else if (!permit || !cmd) ns = M_OPENING;
                else if (m_time_in_state + 1 >= CT) begin ns = M_FAULT; m_code = 1; end
            end
            M_CLOSED: begin
                if (!m_fb) begin ns = M_FAULT; m_code = 3; end
                else if (!permit || !cmd) ns = M_OPENING;
            end
            M_OPENING: begin
                if (!m_fb) ns = M_OPEN;
                else if (m_time_in_state + 1 >= OT) begin ns = M_FAULT; m_code = 2; end
            end
            default: begin
                if (clr && !m_fb) begin ns = M_OPEN; m_code = 0; end
            end
        endcase
        m_time_in_state = (ns == m_state) ? m_time_in_state + 1 : 0;
        m_state = ns;
        if (flip) m_fb = ~m_fb;
        raw_hist.push_front(aux);
        void'(raw_hist.pop_back());
    endtask

    function automatic logic exp_coil();
        logic c;
        c = (m_state == M_CLOSING) || (m_state == M_CLOSED);
`ifdef CONTACTOR_PERMIT_GATE_EN
        c = c & permit;
`endif
        return c;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".coil"}, {3'b0, coil}, {3'b0, exp_coil()});
        chk({tag, ".fb"}, {3'b0, fb}, {3'b0, m_fb});
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, (m_state == M_CLOSING) || (m_state == M_OPENING)});
        chk({tag, ".fault"}, {3'b0, fault}, {3'b0, m_state == M_FAULT});
        chk({tag, ".code"}, {2'b0, code}, 4'(m_code));
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all(tag);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_pulse(input string tag);
        clr = 1'b1;
        step(tag, 1);
        clr = 1'b0;
    endtask

    initial begin
        bit rcoil;
        int r;
        do_reset();
        check_all("reset");
        chk("reset.coil_const", {3'b0, coil}, 4'd0);

        // Normal close and open
        cmd = 1'b1; permit = 1'b1;
        step("close", 1);
        chk("close.coil_on", {3'b0, coil}, 4'd1);
        chk("close.busy_on", {3'b0, busy}, 4'd1);
        step("close", 2);
        aux = 1'b1;
        step("close", 5);
        chk("close.fb_before", {3'b0, fb}, 4'd0);
        step("close", 1);
        chk("close.fb_after6", {3'b0, fb}, 4'd1);
        step("close", 1);
        chk("close.closed_busy", {3'b0, busy}, 4'd0);
        chk("close.closed_coil", {3'b0, coil}, 4'd1);
        cmd = 1'b0;
        step("open", 1);
        chk("open.coil_off", {3'b0, coil}, 4'd0);
        aux = 1'b0;
        step("open", 8);
        chk("open.fb", {3'b0, fb}, 4'd0);
        chk("open.busy", {3'b0, busy}, 4'd0);

        // Fail-to-close
        cmd = 1'b1; permit = 1'b1;
        step("ftc", 20);
        chk("ftc.not_yet", {3'b0, fault}, 4'd0);
        step("ftc", 1);
        chk("ftc.fault", {3'b0, fault}, 4'd1);
        chk("ftc.code", {2'b0, code}, 4'd1);
        chk("ftc.coil", {3'b0, coil}, 4'd0);
        cmd = 1'b0;
        clear_pulse("ftc_clr");
        chk("ftc.cleared", {2'b0, code}, 4'd0);

        // Permit loss while closed, then fail-to-open
        cmd = 1'b1; permit = 1'b1; aux = 1'b1;
        step("ploss", 10);
        chk("ploss.closed", {3'b0, coil}, 4'd1);
        permit = 1'b0;
`ifdef CONTACTOR_PERMIT_GATE_EN
        #1 chk("ploss.coil_gated", {3'b0, coil}, 4'd0);
`else
        #1 chk("ploss.coil_held", {3'b0, coil}, 4'd1);
`endif
        step("ploss", 1);
        chk("ploss.coil_off", {3'b0, coil}, 4'd0);
        step("ploss", 20);
        chk("ploss.fault", {3'b0, fault}, 4'd1);
        chk("ploss.code", {2'b0, code}, 4'd2);
        clear_pulse("ploss_clr_fb1");
        chk("ploss.stays", {3'b0, fault}, 4'd1);
        aux = 1'b0;
        step("ploss", 8);
        clear_pulse("ploss_clr");
        chk("ploss.recovered", {3'b0, fault}, 4'd0);

        // Debounce glitch then real dropout
        cmd = 1'b1; permit = 1'b1; aux = 1'b1;
        step("deb", 10);
        aux = 1'b0;
        step("deb", 3);
        aux = 1'b1;
        step("deb", 6);
        chk("deb.glitch_fb", {3'b0, fb}, 4'd1);
        chk("deb.glitch_fault", {3'b0, fault}, 4'd0);
        aux = 1'b0;
        step("deb", 5);
        aux = 1'b1;
        step("deb", 2);
        chk("deb.drop_fault", {3'b0, fault}, 4'd1);
        chk("deb.drop_code", {2'b0, code}, 4'd3);
        aux = 1'b0; cmd = 1'b0;
        step("deb", 10);
        clear_pulse("deb_clr");

        // Unexpected close while open
        aux = 1'b1;
        step("unexp", 6);
        chk("unexp.fb", {3'b0, fb}, 4'd1);
        step("unexp", 1);
        chk("unexp.fault", {3'b0, fault}, 4'd1);
        chk("unexp.code", {2'b0, code}, 4'd3);
        chk("unexp.coil", {3'b0, coil}, 4'd0);
        aux = 1'b0;
        step("unexp", 8);
        clear_pulse("unexp_clr");

        // Asynchronous reset mid-closing
        cmd = 1'b1; permit = 1'b1;
        step("areset", 3);
        chk("areset.busy_pre", {3'b0, busy}, 4'd1);
        #2 rst = 1'b1;
        #1;
        chk("areset.coil", {3'b0, coil}, 4'd0);
        chk("areset.busy", {3'b0, busy}, 4'd0);
        chk("areset.fb", {3'b0, fb}, 4'd0);
        chk("areset.fault", {3'b0, fault}, 4'd0);
        model_reset();
        cmd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step("areset_post", 2);

        // Randomized operation
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 63));
            rcoil = (m_state == M_CLOSING) || (m_state == M_CLOSED);
            if (r < 3) cmd = ~cmd;
            else if (r < 5) permit = ~permit;
            else if (r < 9) aux = ~aux;
            else if (r < 20) aux = rcoil;
            clr = ($urandom_range(0, 7) == 0);
            step("rand", 1);
        end
        clr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
